// File: rtl/led_seq_monitor_pkg.sv
// Shared definitions for the running-light pattern monitor: legal codes,
// mode encodings and the tracking FSM states.
package led_seq_pkg;

  localparam logic [7:0] C_OFF  = 8'h00;
  localparam logic [7:0] C_C1   = 8'h18;
  localparam logic [7:0] C_C2   = 8'h24;
  localparam logic [7:0] C_C3   = 8'h42;
  localparam logic [7:0] C_EDGE = 8'h81;

  localparam logic M_OUT = 1'b0;
  localparam logic M_IN  = 1'b1;

  typedef enum logic {S_HUNT, S_LOCK} state_t;

  function automatic logic f_is_legal(input logic [7:0] code);
    return (code == C_OFF) || (code == C_C1) || (code == C_C2) ||
           (code == C_C3)  || (code == C_EDGE);
  endfunction

endpackage

// File: rtl/led_seq_monitor_if.sv
// Pattern bus as seen by the monitor: step strobe and code in, tracking status out.
interface led_seq_monitor_if;
  logic        sample_en;
  logic [7:0]  led_in;
  logic        locked;
  logic        mode_det;
  logic [7:0]  expect_nxt;
  logic        mode_chg;
  logic        err;
  logic [7:0]  err_cnt;
  logic [15:0] cyc_cnt;

  modport master (
    output sample_en, led_in,
    input  locked, mode_det, expect_nxt, mode_chg, err, err_cnt, cyc_cnt
  );

  modport slave (
    input  sample_en, led_in,
    output locked, mode_det, expect_nxt, mode_chg, err, err_cnt, cyc_cnt
  );
endinterface

// File: rtl/led_seq_monitor_next.sv
// Successor lookup for one sequence mode; illegal codes map to 00 with valid low.
module led_seq_next
  import led_seq_pkg::*;
(
  input  logic [7:0] code,
  input  logic       mode,
  output logic [7:0] nxt,
  output logic       valid
);

  always_comb begin
    nxt   = C_OFF;
    valid = f_is_legal(code);
    case (code)
      C_OFF:   nxt = (mode == M_IN) ? C_EDGE : C_C1;
      C_C1:    nxt = (mode == M_IN) ? C_OFF  : C_C2;
      C_C2:    nxt = (mode == M_IN) ? C_C1   : C_C3;
      C_C3:    nxt = (mode == M_IN) ? C_C2   : C_EDGE;
      C_EDGE:  nxt = (mode == M_IN) ? C_C3   : C_OFF;
      default: nxt = C_OFF;
    endcase
  end

endmodule

// File: rtl/led_seq_monitor.sv
// Running-light pattern checker: hunts for a legal transition, locks onto the
// mode, then flags illegal steps and counts completed cycles.
module led_seq_monitor
  import led_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  led_seq_monitor_if.slave   bus
);

  state_t      r_state, w_state_next;
  logic [7:0]  r_prev, w_prev_next;
  logic        r_prev_valid, w_prev_valid_next;
  logic        r_mode, w_mode_next;
  logic        r_err, w_err_next;
  logic        r_mode_chg, w_mode_chg_next;
  logic [7:0]  r_err_cnt, w_err_cnt_next;
  logic [15:0] r_cyc_cnt, w_cyc_cnt_next;

  logic [7:0]  w_nxt_out, w_nxt_in, w_cur_nxt, w_alt_nxt;
  logic        w_ok_out, w_ok_in, w_prev_ok, w_in_legal, w_accept;

  led_seq_next u_next_out (.code(r_prev), .mode(M_OUT), .nxt(w_nxt_out), .valid(w_ok_out));
  led_seq_next u_next_in  (.code(r_prev), .mode(M_IN),  .nxt(w_nxt_in),  .valid(w_ok_in));

  assign w_prev_ok  = w_ok_out & w_ok_in;
  assign w_in_legal = f_is_legal(bus.led_in);
  assign w_cur_nxt  = (r_mode == M_IN) ? w_nxt_in  : w_nxt_out;
  assign w_alt_nxt  = (r_mode == M_IN) ? w_nxt_out : w_nxt_in;

  always_comb begin
    w_state_next      = r_state;
    w_prev_next       = r_prev;
    w_prev_valid_next = r_prev_valid;
    w_mode_next       = r_mode;
    w_err_next        = 1'b0;
    w_mode_chg_next   = 1'b0;
    w_err_cnt_next    = r_err_cnt;
    w_cyc_cnt_next    = r_cyc_cnt;
    w_accept          = 1'b0;
    if (bus.sample_en) begin
      case (r_state)
        S_HUNT: begin
          if (!w_in_legal) begin
            w_prev_valid_next = 1'b0;
          end else begin
            w_prev_next       = bus.led_in;
            w_prev_valid_next = 1'b1;
            // Mode transition sets are disjoint, so one legal step fixes the mode.
            if (r_prev_valid && w_prev_ok) begin
              if (bus.led_in == w_nxt_out) begin
                w_state_next = S_LOCK;
                w_mode_next  = M_OUT;
              end else if (bus.led_in == w_nxt_in) begin
                w_state_next = S_LOCK;
                w_mode_next  = M_IN;
              end
            end
          end
        end
        S_LOCK: begin
          w_prev_next = bus.led_in;
          if (bus.led_in == w_cur_nxt) begin
            w_accept = 1'b1;
          end else if (bus.led_in == w_alt_nxt) begin
            w_accept        = 1'b1;
            w_mode_next     = ~r_mode;
            w_mode_chg_next = 1'b1;
          end else begin
            w_err_next        = 1'b1;
            w_state_next      = S_HUNT;
            w_prev_valid_next = w_in_legal;
            if (r_err_cnt != 8'hFF) w_err_cnt_next = r_err_cnt + 8'd1;
          end
          if (w_accept && (bus.led_in == C_OFF)) w_cyc_cnt_next = r_cyc_cnt + 16'd1;
        end
        default: w_state_next = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_HUNT;
      r_prev       <= C_OFF;
      r_prev_valid <= 1'b0;
      r_mode       <= M_OUT;
      r_err        <= 1'b0;
      r_mode_chg   <= 1'b0;
      r_err_cnt    <= 8'h00;
      r_cyc_cnt    <= 16'h0000;
    end else begin
      r_state      <= w_state_next;
      r_prev       <= w_prev_next;
      r_prev_valid <= w_prev_valid_next;
      r_mode       <= w_mode_next;
      r_err        <= w_err_next;
      r_mode_chg   <= w_mode_chg_next;
      r_err_cnt    <= w_err_cnt_next;
      r_cyc_cnt    <= w_cyc_cnt_next;
    end
  end

  // Prediction is decoded purely from registered state, so it never depends on inputs.
  assign bus.locked     = (r_state == S_LOCK);
  assign bus.mode_det   = r_mode;
  assign bus.expect_nxt = (r_state == S_LOCK) ? w_cur_nxt : C_OFF;
  assign bus.mode_chg   = r_mode_chg;
  assign bus.err        = r_err;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.cyc_cnt    = r_cyc_cnt;

endmodule

// File: tb/tb_led_seq_monitor.sv
// Scoreboard bench: each sample pushes its hand-computed response; a monitor
// pops and compares one cycle after every strobe.
module tb_led_seq_monitor;

  typedef struct {
    logic [7:0]  code;
    logic        locked;
    logic        mode;
    logic [7:0]  nxt;
    logic        chg;
    logic        err;
    logic [7:0]  err_cnt;
    logic [15:0] cyc_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  logic [7:0]  e_err_cnt = 8'h00;
  logic [15:0] e_cyc_cnt = 16'h0000;
  bit          e_was_locked = 1'b0;

  led_seq_monitor_if bus_if();

  led_seq_monitor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One strobe; bench-side counters follow the hand-given err/lock expectations.
  task automatic sample(input logic [7:0] code, input bit rst, input bit lk,
                        input bit md, input logic [7:0] nx, input bit chg, input bit er);
    exp_t e;
    if (rst) begin
      e_err_cnt = 8'h00;
      e_cyc_cnt = 16'h0000;
    end else begin
      if (er && e_err_cnt != 8'hFF) e_err_cnt = e_err_cnt + 8'd1;
      if (e_was_locked && !er && code == 8'h00) e_cyc_cnt = e_cyc_cnt + 16'd1;
    end
    e_was_locked = lk;
    e.code = code; e.locked = lk; e.mode = md; e.nxt = nx; e.chg = chg; e.err = er;
    e.err_cnt = e_err_cnt; e.cyc_cnt = e_cyc_cnt;
    sb_q.push_back(e);
    bus_if.sample_en = 1'b1;
    bus_if.led_in    = code;
    reset            = rst;
    @(posedge clk); #1;
    bus_if.sample_en = 1'b0;
    reset            = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: a strobe at the last edge means a response is due now.
  initial begin
    bit   took;
    exp_t e;
    forever begin
      @(posedge clk);
      took = bus_if.sample_en;
      @(negedge clk);
      if (took) begin
        if (sb_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL scoreboard: response with empty queue, required queued entry");
        end else begin
          e = sb_q.pop_front();
          $display("sample %02h: locked=%0d mode=%0d nxt=%02h chg=%0d err=%0d err_cnt=%02h cyc=%04h",
                   e.code, bus_if.locked, bus_if.mode_det, bus_if.expect_nxt,
                   bus_if.mode_chg, bus_if.err, bus_if.err_cnt, bus_if.cyc_cnt);
          chk("locked", int'(bus_if.locked), int'(e.locked));
          if (e.locked) chk("mode_det", int'(bus_if.mode_det), int'(e.mode));
          chk("expect_nxt", int'(bus_if.expect_nxt), int'(e.nxt));
          chk("mode_chg", int'(bus_if.mode_chg), int'(e.chg));
          chk("err", int'(bus_if.err), int'(e.err));
          chk("err_cnt", int'(bus_if.err_cnt), int'(e.err_cnt));
          chk("cyc_cnt", int'(bus_if.cyc_cnt), int'(e.cyc_cnt));
        end
      end else begin
        chk("idle_err", int'(bus_if.err), 0);
        chk("idle_mode_chg", int'(bus_if.mode_chg), 0);
      end
    end
  end

  initial begin
    bus_if.sample_en = 1'b0;
    bus_if.led_in    = 8'h00;
    reset            = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_locked", int'(bus_if.locked), 0);
    chk("rst_mode", int'(bus_if.mode_det), 0);
    chk("rst_nxt", int'(bus_if.expect_nxt), 0);
    chk("rst_err_cnt", int'(bus_if.err_cnt), 0);
    chk("rst_cyc_cnt", int'(bus_if.cyc_cnt), 0);

    // Outward cycle, full rate
    sample(8'h00, 0, 0, 0, 8'h00, 0, 0);
    sample(8'h18, 0, 1, 0, 8'h24, 0, 0);
    sample(8'h24, 0, 1, 0, 8'h42, 0, 0);
    sample(8'h42, 0, 1, 0, 8'h81, 0, 0);
    sample(8'h81, 0, 1, 0, 8'h00, 0, 0);
    sample(8'h00, 0, 1, 0, 8'h18, 0, 0);

    // Inward cycle after a fresh reset
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    e_err_cnt = 8'h00; e_cyc_cnt = 16'h0000; e_was_locked = 1'b0;
    sample(8'h00, 0, 0, 0, 8'h00, 0, 0);
    sample(8'h81, 0, 1, 1, 8'h42, 0, 0);
    sample(8'h42, 0, 1, 1, 8'h24, 0, 0);
    sample(8'h24, 0, 1, 1, 8'h18, 0, 0);
    sample(8'h18, 0, 1, 1, 8'h00, 0, 0);
    sample(8'h00, 0, 1, 1, 8'h81, 0, 0);

    // Legal mode switches
    sample(8'h18, 0, 1, 0, 8'h24, 1, 0);
    sample(8'h24, 0, 1, 0, 8'h42, 0, 0);
    sample(8'h18, 0, 1, 1, 8'h00, 1, 0);
    sample(8'h00, 0, 1, 1, 8'h81, 0, 0);
    sample(8'h81, 0, 1, 1, 8'h42, 0, 0);
    sample(8'h42, 0, 1, 1, 8'h24, 0, 0);

    // Invalid code, then re-lock
    sample(8'h55, 0, 0, 0, 8'h00, 0, 1);
    sample(8'h18, 0, 0, 0, 8'h00, 0, 0);
    sample(8'h24, 0, 1, 0, 8'h42, 0, 0);

    // Repeated code, then drive the error counter into saturation
    sample(8'h24, 0, 0, 0, 8'h00, 0, 1);
    sample(8'h42, 0, 1, 0, 8'h81, 0, 0);
    for (int i = 0; i < 128; i++) begin
      sample(8'h42, 0, 0, 0, 8'h00, 0, 1);
      sample(8'h24, 0, 1, 1, 8'h18, 0, 0);
      sample(8'h24, 0, 0, 0, 8'h00, 0, 1);
      sample(8'h42, 0, 1, 0, 8'h81, 0, 0);
    end
    chk("err_cnt_sat", int'(bus_if.err_cnt), 8'hFF);

    // Reset beats a simultaneous strobe; gapped strobes re-lock
    sample(8'h81, 1, 0, 0, 8'h00, 0, 0);
    idle(3);
    sample(8'h81, 0, 0, 0, 8'h00, 0, 0);
    idle(3);
    sample(8'h00, 0, 1, 0, 8'h18, 0, 0);
    idle(3);
    sample(8'h18, 0, 1, 0, 8'h24, 0, 0);
    idle(3);
    chk("gap_hold_nxt", int'(bus_if.expect_nxt), 8'h24);

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_seq_monitor.md
# led_seq_monitor

Receive-side checker for the 8-bit running-light (progressive LED) pattern bus. It samples the pattern on each step strobe, identifies which of the two sequence modes is running, locks onto it, predicts the next code, and flags and counts illegal steps and completed cycles. It sits beside the pattern generator, or at a remote end of the LED bus, for self-test and board bring-up.

## Interface
- No parameters. Widths are fixed by the pattern definition.
- `clk` — input, 1 — clock; all logic is rising-edge.
- `reset` — input, 1 — synchronous, active-high reset.
- `sample_en` — input, 1 — step strobe, high for one cycle per generator step; `led_in` is valid in that cycle.
- `led_in` — input, 8 — observed pattern code.
- `locked` — output, 1 — high while the monitor is tracking a valid sequence.
- `mode_det` — output, 1 — detected mode: 0 = outward (centre to edge), 1 = inward (edge to centre). Meaningful only while `locked` is high.
- `expect_nxt` — output, 8 — predicted next code while locked; 8'h00 otherwise.
- `mode_chg` — output, 1 — one-cycle pulse when the sequence legally switched mode.
- `err` — output, 1 — one-cycle pulse on an illegal step while locked.
- `err_cnt` — output, 8 — error count; saturates at 8'hFF.
- `cyc_cnt` — output, 16 — count of completed cycles; wraps modulo 2^16.

## Operation
- Legal codes are 00, 18, 24, 42, 81. Any other value is an invalid code.
- Mode 0 successors: 00→18→24→42→81→00.
- Mode 1 successors: 00→81→42→24→18→00.
- The two transition sets are disjoint, so a single legal transition determines the mode.
- Internal state: `prev[7:0]`, `prev_valid`, and a two-state FSM {HUNT, LOCK}.
- HUNT, on `sample_en`:
  - Invalid code: clear `prev_valid`.
  - Else if `prev_valid` and (`prev`, `led_in`) is a mode-m transition: go to LOCK and set `mode_det` = m.
  - Else: `prev` ← `led_in`, `prev_valid` ← 1.
  - No `err` is raised in HUNT.
- LOCK, on `sample_en`:
  - `led_in` = successor(`prev`, `mode_det`): accept the step.
  - `led_in` = successor(`prev`, !`mode_det`): accept, toggle `mode_det`, pulse `mode_chg`.
  - Anything else, including a repeated code or an invalid code: pulse `err`, increment `err_cnt` (saturating), go to HUNT. `prev` ← `led_in` and `prev_valid` ← valid(`led_in`).
- `cyc_cnt` increments on every accepted LOCK step whose `led_in` is 00.
- `prev` updates on every `sample_en`, subject to the invalid-code rule in HUNT.
- `expect_nxt` = successor(`prev`, `mode_det`) while in LOCK; 00 in HUNT.
- With `sample_en` low: all state holds and `err` and `mode_chg` are 0.

## Timing
- All outputs are registered. The effects of a sample at edge N are visible after edge N; `err` and `mode_chg` are high for exactly that one cycle.
- Lock latency: two consecutive legal samples. `locked` rises after the second.
- On `reset`, all outputs go to 0: `locked` 0, `mode_det` 0, `expect_nxt` 00, `err` 0, `mode_chg` 0, `err_cnt` 0, `cyc_cnt` 0. FSM goes to HUNT and `prev_valid` to 0.
- `reset` dominates `sample_en` in the same cycle.
- Reset mid-sequence discards the lock; re-lock needs two fresh samples.
- Back-to-back `sample_en` (every cycle) must be supported at full rate.
- `err_cnt` at FF plus a further error: stays FF, and `err` still pulses.
- `cyc_cnt` at FFFF plus a completed cycle: wraps to 0000.

## Structure
- Package `led_seq_pkg` holds:
  - code constants `C_OFF`=00, `C_C1`=18, `C_C2`=24, `C_C3`=42, `C_EDGE`=81;
  - mode constants `M_OUT`=0, `M_IN`=1;
  - FSM enum `{S_HUNT, S_LOCK}`.
- Sub-module `led_seq_next` (combinational): inputs `code[7:0]` and `mode`; outputs `nxt[7:0]` and `valid` (code is legal). It is instantiated twice, once per mode, on `prev`; `valid` is also used on `led_in`.
- The top level contains the FSM, the `prev` register, and the counters.

## Test plan
- Reset, then `led_in` 00, 18, 24, 42, 81, 00 on `sample_en` → `locked` rises after 18 with `mode_det`=0 and `expect_nxt`=24; `cyc_cnt`=1 after the final 00; `err`=0 throughout.
- Sequence 00, 81, 42, 24, 18, 00 → lock after 81 with `mode_det`=1 and `expect_nxt`=42; `cyc_cnt`=1.
- Locked mode 0 at 24, then 18 → `mode_chg` pulses, `mode_det`=1, `expect_nxt`=00, no `err`.
- Locked at 42, then 55 → `err` pulses, `err_cnt`=1, `locked`=0; then 18, 24 → re-lock mode 0.
- Locked, repeat 24, 24 → `err` pulses; force 256 errors → `err_cnt`=FF and `err` still pulses.
- `reset` asserted together with `sample_en` while locked → all outputs 0; the next two legal samples re-lock; `sample_en` gaps of 3 cycles change nothing.
